// File: rtl/fft_pkg.sv
// Shared types and address generation for the radix-2 in-place FFT butterfly scheduler.
package fft_pkg;

  localparam int MAX_LOG2N = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [MAX_LOG2N-1:0] addr0;
    logic [MAX_LOG2N-1:0] addr1;
    logic [MAX_LOG2N-2:0] tw;
  } addr_set_t;

  // Butterfly k of stage s pairs addr0 with addr0+half; twiddle stride shrinks as s grows.
  function automatic addr_set_t fft_addr(input int s, input int k, input int log2n);
    int half;
    int pos;
    int grp;
    int a0;
    addr_set_t r;
    half    = 1 << s;
    pos     = k & (half - 1);
    grp     = k >> s;
    a0      = (grp << (s + 1)) | pos;
    r.addr0 = MAX_LOG2N'(a0);
    r.addr1 = MAX_LOG2N'(a0 + half);
    r.tw    = (MAX_LOG2N-1)'(pos << (log2n - 1 - s));
    return r;
  endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Enable-gated shift register that turns issued read pairs into write-back pairs
// exactly DEPTH advancing cycles later.
module fft_wb_delay #(
  parameter int DEPTH = 2,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          push_valid,
  input  logic [AW-1:0] push_addr0,
  input  logic [AW-1:0] push_addr1,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr0,
  output logic [AW-1:0] wb_addr1
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
  } wb_t;

  wb_t line_q [DEPTH];

  // NOTE: every tap is reset (not just valid) so write addresses read 0 while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else if (en) begin
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
      end else begin
        line_q[0] <= '{valid: push_valid, addr0: push_addr0, addr1: push_addr1};
        for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
      end
    end
  end

  assign wb_valid = line_q[DEPTH-1].valid;
  assign wb_addr0 = line_q[DEPTH-1].addr0;
  assign wb_addr1 = line_q[DEPTH-1].addr1;

endmodule

// File: rtl/fft_bf_scheduler.sv
// Stage/butterfly sequencer for an in-place radix-2 N-point FFT memory.
// Optional macro FFT_SCHED_ABORT_EN adds an abort input that cancels a transform.
module fft_bf_scheduler
  import fft_pkg::*;
#(
  parameter int LOG2N      = 4,
  parameter int BF_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       start,
`ifdef FFT_SCHED_ABORT_EN
  input  logic                       abort,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(LOG2N)-1:0]   stage,
  output logic                       rd_valid,
  output logic [LOG2N-1:0]           rd_addr0,
  output logic [LOG2N-1:0]           rd_addr1,
  output logic [LOG2N-2:0]           tw_idx,
  output logic                       wr_valid,
  output logic [LOG2N-1:0]           wr_addr0,
  output logic [LOG2N-1:0]           wr_addr1
);

  localparam int SW = $clog2(LOG2N);
  localparam int KW = LOG2N - 1;
  localparam int DW = 4;

  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [DW-1:0] D_LAST = DW'(BF_LATENCY - 1);

  state_t        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] d_q, d_d;
  logic          clr;
  addr_set_t     ag;

`ifdef FFT_SCHED_ABORT_EN
  assign clr = abort;
`else
  assign clr = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      d_q     <= '0;
    end else if (en) begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      d_q     <= d_d;
    end
  end

  // NOTE: every next-state signal gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    d_d     = d_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          s_d     = '0;
          k_d     = '0;
        end
      end
      ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          d_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DRAIN: begin
        if (d_q == D_LAST) begin
          if (s_q == S_LAST) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            s_d     = s_q + SW'(1);
            k_d     = '0;
          end
        end else begin
          d_d = d_q + DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        s_d     = '0;
      end
    endcase
    // Abort overrides everything, including a simultaneous start.
    if (clr) begin
      state_d = IDLE;
      s_d     = '0;
      k_d     = '0;
      d_d     = '0;
    end
  end

  always_comb ag = fft_addr(int'(s_q), int'(k_q), LOG2N);

  assign busy     = (state_q == ISSUE) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign stage    = s_q;
  assign rd_valid = (state_q == ISSUE);
  assign rd_addr0 = rd_valid ? ag.addr0[LOG2N-1:0] : '0;
  assign rd_addr1 = rd_valid ? ag.addr1[LOG2N-1:0] : '0;
  assign tw_idx   = rd_valid ? ag.tw[LOG2N-2:0]    : '0;

  fft_wb_delay #(
    .DEPTH (BF_LATENCY),
    .AW    (LOG2N)
  ) u_wb_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .push_valid (rd_valid),
    .push_addr0 (rd_addr0),
    .push_addr1 (rd_addr1),
    .wb_valid   (wr_valid),
    .wb_addr0   (wr_addr0),
    .wb_addr1   (wr_addr1)
  );

endmodule

// File: tb/tb_fft_bf_scheduler.sv
// Randomized-enable bench for fft_bf_scheduler against a per-cycle transform trace model.
module tb_fft_bf_scheduler;

  localparam int LOG2N      = 4;
  localparam int BF_LATENCY = 2;
  localparam int N          = 1 << LOG2N;
  localparam int HALF_N     = N / 2;
  localparam int TOTAL      = LOG2N * (HALF_N + BF_LATENCY);

  typedef struct {
    logic v;
    int   a0;
    int   a1;
    int   tw;
    logic busy;
    logic done;
    int   stage;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic start = 1'b0;
`ifdef FFT_SCHED_ABORT_EN
  logic abort = 1'b0;
`endif
  logic                     busy, done, rd_valid, wr_valid;
  logic [$clog2(LOG2N)-1:0] stage;
  logic [LOG2N-1:0]         rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic [LOG2N-2:0]         tw_idx;

  int   checks = 0;
  int   errors = 0;
  ent_t exp_q[$];
  ent_t zero_e;

  fft_bf_scheduler #(.LOG2N(LOG2N), .BF_LATENCY(BF_LATENCY)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .start    (start),
`ifdef FFT_SCHED_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .stage    (stage),
    .rd_valid (rd_valid),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .tw_idx   (tw_idx),
    .wr_valid (wr_valid),
    .wr_addr0 (wr_addr0),
    .wr_addr1 (wr_addr1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack(input logic v, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] c);
    return (32'(v) << 30) | (a << 20) | (b << 10) | c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Trace model: in stage s the pairs are every index whose bit s is clear,
  // ascending, with partner index+2^s and twiddle (index mod 2^s) * N/2^(s+1).
  task automatic build_model();
    ent_t e;
    exp_q.delete();
    for (int s = 0; s < LOG2N; s++) begin
      for (int i = 0; i < N; i++) begin
        if (((i >> s) % 2) == 0) begin
          e = '{v: 1'b1, a0: i, a1: i + (1 << s), tw: (i % (1 << s)) * (N >> (s + 1)),
                busy: 1'b1, done: 1'b0, stage: s};
          exp_q.push_back(e);
        end
      end
      for (int d = 0; d < BF_LATENCY; d++) begin
        e = '{v: 1'b0, a0: 0, a1: 0, tw: 0, busy: 1'b1, done: 1'b0, stage: s};
        exp_q.push_back(e);
      end
    end
    e = '{v: 1'b0, a0: 0, a1: 0, tw: 0, busy: 1'b0, done: 1'b1, stage: LOG2N - 1};
    exp_q.push_back(e);
  endtask

  task automatic check_outputs(input string tag, input ent_t e, input ent_t w);
    check({tag, ".rd"}, pack(rd_valid, 32'(rd_addr0), 32'(rd_addr1), 32'(tw_idx)),
          pack(e.v, e.a0, e.a1, e.tw));
    check({tag, ".wr"}, pack(wr_valid, 32'(wr_addr0), 32'(wr_addr1), 32'd0),
          pack(w.v, w.a0, w.a1, 32'd0));
    check({tag, ".ctrl"}, pack(busy, 32'(done), 32'(stage), 32'd0),
          pack(e.busy, 32'(e.done), e.stage, 32'd0));
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check_outputs(tag, zero_e, zero_e);
      @(negedge clk);
    end
  endtask

  // Starts a transform from IDLE at a negedge. Stops early (before checking)
  // when the trace index reaches stop_idx; otherwise runs through DONE.
  task automatic run_transform(input string tag, input int en_pct,
                               input int restart_idx, input int stop_idx);
    int idx = 0;
    int cyc = 0;
    en    = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (idx <= TOTAL && idx != stop_idx) begin
      check_outputs(tag, exp_q[idx], (idx >= BF_LATENCY) ? exp_q[idx - BF_LATENCY] : zero_e);
      if (idx == 3)
        check("addr_s0_k3", pack(rd_valid, 32'(rd_addr0), 32'(rd_addr1), 32'(tw_idx)),
              pack(1'b1, 6, 7, 0));
      if (idx == 2 * (HALF_N + BF_LATENCY) + 5)
        check("addr_s2_k5", pack(rd_valid, 32'(rd_addr0), 32'(rd_addr1), 32'(tw_idx)),
              pack(1'b1, 9, 13, 2));
      if (idx == 3 * (HALF_N + BF_LATENCY) + 7)
        check("addr_s3_k7", pack(rd_valid, 32'(rd_addr0), 32'(rd_addr1), 32'(tw_idx)),
              pack(1'b1, 7, 15, 7));
      en    = ($urandom_range(99) < en_pct);
      start = (idx == restart_idx);
      if (en) idx++;
      @(negedge clk);
      cyc++;
      if (cyc > 4000) begin
        check({tag, ".cycle_budget"}, idx, TOTAL + 1);
        break;
      end
    end
    en    = 1'b1;
    start = 1'b0;
    if (stop_idx > TOTAL) idle_cycles({tag, ".after_done"}, 3);
  endtask

  initial begin
    zero_e = '{v: 1'b0, a0: 0, a1: 0, tw: 0, busy: 1'b0, done: 1'b0, stage: 0};
    build_model();

    // Reset: outputs zero while held, even with en and start high.
    en = 1'b1;
    start = 1'b1;
    #1;
    idle_cycles("in_reset", 3);
    start = 1'b0;
    rst_n = 1'b1;
    idle_cycles("post_reset", 2);

    run_transform("full", 100, -1, TOTAL + 1);
    idle_cycles("gap1", $urandom_range(1, 4));

    run_transform("en_rand", 50, -1, TOTAL + 1);
    idle_cycles("gap2", $urandom_range(1, 4));

    run_transform("restart", 100, 5, TOTAL + 1);
    idle_cycles("gap3", 2);

    // Reset on the first DRAIN cycle of stage 2, then a fresh transform.
    run_transform("pre_rst", 100, -1, 2 * (HALF_N + BF_LATENCY) + HALF_N);
    rst_n = 1'b0;
    #1;
    check_outputs("rst_now", zero_e, zero_e);
    @(negedge clk);
    idle_cycles("rst_hold", 2);
    rst_n = 1'b1;
    idle_cycles("rst_after", BF_LATENCY + 3);
    run_transform("post_rst", 60, -1, TOTAL + 1);

`ifdef FFT_SCHED_ABORT_EN
    // Abort at stage 1, k=4, together with a start that must lose.
    run_transform("pre_abort", 100, -1, (HALF_N + BF_LATENCY) + 4);
    check_outputs("abort_point", exp_q[HALF_N + BF_LATENCY + 4], exp_q[HALF_N + 4]);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    idle_cycles("after_abort", BF_LATENCY + 4);
    run_transform("post_abort", 100, -1, TOTAL + 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bf_scheduler.md
FFT_BF_SCHEDULER -- requirements
Module: fft_bf_scheduler

Interface
REQ-001 SHALL have parameter LOG2N, default 4, meaning log2 of FFT size N (legal 2..10).
REQ-002 SHALL have parameter BF_LATENCY, default 2, meaning butterfly read-to-result latency in cycles (legal 1..8).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, meaning global advance; low freezes all state.
REQ-006 SHALL have port start, input, 1, meaning request one in-place N-point transform.
REQ-007 SHALL have port busy, output, 1, meaning transform in progress.
REQ-008 SHALL have port done, output, 1, meaning one-cycle completion pulse.
REQ-009 SHALL have port stage, output, $clog2(LOG2N), meaning current stage index s.
REQ-010 SHALL have port rd_valid, output, 1, meaning operand pair read issued this cycle.
REQ-011 SHALL have ports rd_addr0 and rd_addr1, output, LOG2N each, meaning operand addresses.
REQ-012 SHALL have port tw_idx, output, LOG2N-1, meaning twiddle ROM index for the issued pair.
REQ-013 SHALL have port wr_valid, output, 1, meaning butterfly results are to be written this cycle.
REQ-014 SHALL have ports wr_addr0 and wr_addr1, output, LOG2N each, meaning write-back addresses for out0 and out1.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE; transitions occur only on cycles with en=1.
REQ-016 IDLE SHALL move to ISSUE with s=0 and k=0 when start=1; start SHALL be ignored in all other states.
REQ-017 ISSUE SHALL assert rd_valid every cycle and increment k from 0 to N/2-1, then move to DRAIN.
REQ-018 Address rules: half=1<<s, pos=k&(half-1), grp=k>>s, rd_addr0=(grp<<(s+1))|pos, rd_addr1=rd_addr0+half, tw_idx=pos<<(LOG2N-1-s).
REQ-019 DRAIN SHALL last exactly BF_LATENCY enabled cycles with rd_valid=0, then go to ISSUE with s+1 and k=0, or to DONE if s=LOG2N-1.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-021 busy SHALL be 1 in ISSUE and DRAIN and 0 in IDLE and DONE.
REQ-022 wr_valid, wr_addr0 and wr_addr1 SHALL equal rd_valid, rd_addr0 and rd_addr1 delayed by exactly BF_LATENCY enabled cycles.
REQ-023 With en held high, SHALL need exactly LOG2N*(N/2+BF_LATENCY) cycles from the first ISSUE cycle to the DONE cycle.
REQ-024 With en=0, no counter, FSM or delay-line state SHALL change, and all outputs SHALL hold.
REQ-025 When rd_valid=0, rd_addr0, rd_addr1 and tw_idx SHALL be 0.

Reset
REQ-026 rst_n=0 SHALL asynchronously force the FSM to IDLE and clear s, k and the delay line.
REQ-027 During and after reset, all outputs SHALL be 0 until the next start.
REQ-028 Reset asserted mid-transform SHALL abandon the transform with no done pulse, including pending wr_valid.

Configuration
REQ-029 Macro FFT_SCHED_ABORT_EN: when defined, SHALL add input port abort, 1 bit.
REQ-030 With FFT_SCHED_ABORT_EN defined, abort=1 with en=1 SHALL, at the next edge, move to IDLE, clear the delay line and pulse no done; abort SHALL take priority over start.
REQ-031 Without FFT_SCHED_ABORT_EN, the port SHALL be absent and behaviour SHALL be as specified above.

Structure
REQ-032 Package fft_pkg SHALL hold the FSM state enum type and an address-generation function (s, k, LOG2N -> addr0, addr1, tw_idx).
REQ-033 Sub-module fft_wb_delay SHALL hold the BF_LATENCY-deep enable-gated shift register of {valid, addr0, addr1}.

Verification
REQ-034 LOG2N=4, BF_LATENCY=2, start pulse: rd_valid high 8 cycles per stage; done exactly 40 cycles after the first ISSUE cycle; busy low in the done cycle.
REQ-035 Address check, N=16: s=0,k=3 -> 6/7, tw 0; s=2,k=5 -> 9/13, tw 2; s=3,k=7 -> 7/15, tw 7.
REQ-036 en toggled randomly 50% during a transform: address and wr sequence identical to the en=1 run, done after exactly 40 enabled cycles.
REQ-037 start asserted again at cycle 5 of a transform: ignored, single done pulse, no sequence restart.
REQ-038 rst_n low during stage 2 DRAIN: all outputs 0 immediately, no wr_valid or done afterwards; a new start then runs a full 40-cycle transform.
REQ-039 FFT_SCHED_ABORT_EN defined, abort at stage 1, k=4: IDLE next cycle, wr_valid 0 from then on, no done pulse.
